// File: rtl/mul_result_collector_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mul_result_collector_pkg
//  Brief    : Shared multiplier definitions: element-width encoding, collector
//             state encoding, lane count default and product chunk width.
//  Revision : 1.0  initial release
// ============================================================================
package mul_result_collector_pkg;

    localparam int c_LANES_DEFAULT = 16;
    localparam int c_CHUNK_W       = 64;
    localparam int c_WORD_W        = 32;

    // Element width selector as issued to the multiplier array
    typedef enum logic [1:0] {
        SEW_8    = 2'b00,
        SEW_16   = 2'b01,
        SEW_32   = 2'b10,
        SEW_RSVD = 2'b11
    } sew_e;

    // Collector control states
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_HOLD = 2'b10
    } coll_state_e;

endpackage : mul_result_collector_pkg
`default_nettype wire

// File: rtl/mul_result_collector_if.sv
`default_nettype none
// ============================================================================
//  Module   : mul_result_collector_if
//  Brief    : Operation/lane/result bundle between the lane array side and
//             the result collector.
//  Revision : 1.0  initial release
// ============================================================================
interface mul_result_collector_if
    import mul_result_collector_pkg::*;
#(
    parameter int LANES = c_LANES_DEFAULT
);

    logic                         start;
    logic [1:0]                   sew;
    logic                         hi_sel;
    logic [LANES-1:0]             lane_done;
    logic [c_CHUNK_W*LANES-1:0]   product;
    logic [c_WORD_W*LANES-1:0]    result;
    logic                         result_valid;
    logic                         result_ready;
    logic                         busy;
    logic [1:0]                   err;

    // Issuing / consuming side
    modport master (
        output start, sew, hi_sel, lane_done, product, result_ready,
        input  result, result_valid, busy, err
    );

    // Collector side
    modport slave (
        input  start, sew, hi_sel, lane_done, product, result_ready,
        output result, result_valid, busy, err
    );

endinterface : mul_result_collector_if
`default_nettype wire

// File: rtl/mul_lane_narrow.sv
`default_nettype none
// ============================================================================
//  Module   : mul_lane_narrow
//  Brief    : Selects the low or high half of every element product held in
//             one 64-bit lane chunk and packs the halves into a 32-bit word.
//  Revision : 1.0  initial release
// ============================================================================
module mul_lane_narrow
    import mul_result_collector_pkg::*;
(
    input  wire logic [c_CHUNK_W-1:0] i_chunk,
    input  wire sew_e                 i_sew,
    input  wire logic                 i_hi_sel,
    output logic [c_WORD_W-1:0]       o_word
);

    // Pure bit selection: each element contributes its chosen half, element 0 in the LSBs
    always_comb begin
        o_word = '0;
        case (i_sew)
            SEW_32: begin
                o_word = i_hi_sel ? i_chunk[63:32] : i_chunk[31:0];
            end
            SEW_16: begin
                o_word = i_hi_sel ? {i_chunk[63:48], i_chunk[31:16]}
                                  : {i_chunk[47:32], i_chunk[15:0]};
            end
            SEW_8: begin
                o_word = i_hi_sel ? {i_chunk[63:56], i_chunk[47:40],
                                     i_chunk[31:24], i_chunk[15:8]}
                                  : {i_chunk[55:48], i_chunk[39:32],
                                     i_chunk[23:16], i_chunk[7:0]};
            end
            default: begin
                o_word = '0;
            end
        endcase
    end

endmodule : mul_lane_narrow
`default_nettype wire

// File: rtl/mul_result_collector.sv
`default_nettype none
// ============================================================================
//  Module   : mul_result_collector
//  Brief    : Waits for every multiplier lane to report completion, narrows
//             the lane products into the result vector and holds it until the
//             consumer accepts it. A stuck lane forces a timeout abort.
//  Revision : 1.0  initial release
// ============================================================================
module mul_result_collector
    import mul_result_collector_pkg::*;
#(
    parameter int LANES          = c_LANES_DEFAULT,
    parameter int TIMEOUT_CYCLES = 48
)(
    input  wire logic              clk,
    input  wire logic              reset,
    mul_result_collector_if.slave  bus
);

    localparam int                 c_CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX  = '1;

    coll_state_e               r_state;
    coll_state_e               w_state_nxt;
    sew_e                      r_sew;
    logic                      r_hi_sel;
    logic [LANES-1:0]          r_mask;
    logic [c_CNT_W-1:0]        r_count;
    logic [c_WORD_W*LANES-1:0] r_result;
    logic                      r_valid;
    logic [1:0]                r_err;

    logic [c_WORD_W*LANES-1:0] w_narrow;
    logic                      w_all_done;
    logic                      w_timeout;
    logic                      w_accept;
    logic                      w_complete;
    logic                      w_abort;
    logic                      w_release;

    // Lanes finishing this cycle count toward completion immediately
    assign w_all_done = &(r_mask | bus.lane_done);
    assign w_timeout  = (r_count == c_CNT_LAST);

    generate
        for (genvar k = 0; k < LANES; k++) begin : g_lane
            mul_lane_narrow u_narrow (
                .i_chunk  (bus.product[c_CHUNK_W*k +: c_CHUNK_W]),
                .i_sew    (r_sew),
                .i_hi_sel (r_hi_sel),
                .o_word   (w_narrow[c_WORD_W*k +: c_WORD_W])
            );
        end
    endgenerate

    // Next-state and event decode; completion takes priority over timeout
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_complete  = 1'b0;
        w_abort     = 1'b0;
        w_release   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (w_all_done) begin
                    w_complete  = 1'b1;
                    w_state_nxt = ST_HOLD;
                end else if (w_timeout) begin
                    w_abort     = 1'b1;
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (bus.result_ready) begin
                    w_release   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Operation capture, done-mask/timeout tracking and result holding
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sew    <= SEW_8;
            r_hi_sel <= 1'b0;
            r_mask   <= '0;
            r_count  <= '0;
            r_result <= '0;
            r_valid  <= 1'b0;
            r_err    <= 2'b00;
        end else begin
            if (w_accept) begin
                r_sew    <= sew_e'(bus.sew);
                r_hi_sel <= bus.hi_sel;
                r_mask   <= '0;
                r_count  <= '0;
            end
            if (r_state == ST_WAIT) begin
                r_mask <= r_mask | bus.lane_done;
                if (r_count != c_CNT_MAX) begin
                    r_count <= r_count + c_CNT_W'(1);
                end
            end
            if (w_complete) begin
                r_result <= w_narrow;
                r_err    <= (r_sew == SEW_RSVD) ? 2'b10 : 2'b00;
                r_valid  <= 1'b1;
            end
            if (w_abort) begin
                r_result <= '0;
                r_err    <= 2'b01;
                r_valid  <= 1'b1;
            end
            if (w_release) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign bus.result       = r_result;
    assign bus.result_valid = r_valid;
    assign bus.err          = r_err;
    assign bus.busy         = (r_state != ST_IDLE);

endmodule : mul_result_collector
`default_nettype wire

// File: tb/tb_mul_result_collector.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mul_result_collector
//  Brief    : Self-checking bench for mul_result_collector: directed cases for
//             the documented scenarios plus randomized operations checked
//             against an arithmetic reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mul_result_collector;

    localparam int c_LANES   = 16;
    localparam int c_TIMEOUT = 48;

    logic clk = 1'b0;
    logic reset;
    int   vectors;
    int   miscompares;

    logic [64*c_LANES-1:0] prod;
    logic [32*c_LANES-1:0] exp_res;
    logic [32*c_LANES-1:0] held;
    logic [31:0]           word;
    int                    n;

    always #5 clk = ~clk;

    mul_result_collector_if #(.LANES(c_LANES)) bus ();

    mul_result_collector #(
        .LANES          (c_LANES),
        .TIMEOUT_CYCLES (c_TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Absolute time limit so the run always ends
    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(string tag, logic [511:0] obs, logic [511:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference narrowing from element widths: 64/ew products of ew bits, keep half of each
    function automatic logic [31:0] narrow_ref(logic [63:0] p, logic [1:0] s, logic h);
        int          ew;
        int          hw;
        logic [63:0] emask;
        logic [63:0] hmask;
        logic [63:0] elem;
        logic [63:0] half;
        logic [63:0] acc;
        if (s == 2'b11) return 32'h0;
        ew    = 16 << s;
        hw    = ew / 2;
        emask = (ew == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << ew) - 64'd1);
        hmask = (64'd1 << hw) - 64'd1;
        acc   = '0;
        for (int e = 0; e < 64 / ew; e++) begin
            elem = (p >> (e * ew)) & emask;
            half = h ? (elem >> hw) : (elem & hmask);
            acc  = acc | (half << (e * hw));
        end
        return acc[31:0];
    endfunction

    function automatic logic [32*c_LANES-1:0] ref_vec(logic [64*c_LANES-1:0] p, logic [1:0] s, logic h);
        logic [32*c_LANES-1:0] r;
        for (int k = 0; k < c_LANES; k++) r[32*k +: 32] = narrow_ref(p[64*k +: 64], s, h);
        return r;
    endfunction

    function automatic logic [64*c_LANES-1:0] rand_prod();
        logic [64*c_LANES-1:0] p;
        for (int k = 0; k < c_LANES; k++) p[64*k +: 64] = {$urandom(), $urandom()};
        return p;
    endfunction

    task automatic issue(logic [1:0] s, logic h);
        bus.sew    = s;
        bus.hi_sel = h;
        bus.start  = 1'b1;
        step();
        bus.start  = 1'b0;
    endtask

    task automatic release_op(string tag);
        bus.result_ready = 1'b1;
        step();
        bus.result_ready = 1'b0;
        check({tag, "_rel_valid"}, bus.result_valid, 1'b0);
        check({tag, "_rel_busy"},  bus.busy, 1'b0);
    endtask

    // One operation with random lane completion order and per-cycle products
    task automatic run_random(logic [1:0] s, logic h, int pct, int delay);
        bit                    seen [c_LANES];
        bit                    all;
        bit                    fin;
        logic [c_LANES-1:0]    d;
        logic [64*c_LANES-1:0] p;
        logic [32*c_LANES-1:0] er;
        logic [1:0]            ee;
        int                    cyc;
        issue(s, h);
        bus.sew    = 2'($urandom_range(3));
        bus.hi_sel = 1'($urandom_range(1));
        for (int k = 0; k < c_LANES; k++) seen[k] = 1'b0;
        fin = 1'b0;
        cyc = 0;
        er  = '0;
        ee  = 2'b00;
        while (!fin) begin
            for (int k = 0; k < c_LANES; k++) d[k] = ($urandom_range(99) < pct);
            p = rand_prod();
            bus.lane_done = d;
            bus.product   = p;
            all = 1'b1;
            for (int k = 0; k < c_LANES; k++) begin
                seen[k] = seen[k] | d[k];
                all     = all & seen[k];
            end
            if (all) begin
                er  = ref_vec(p, s, h);
                ee  = (s == 2'b11) ? 2'b10 : 2'b00;
                fin = 1'b1;
            end else if (cyc == c_TIMEOUT - 1) begin
                er  = '0;
                ee  = 2'b01;
                fin = 1'b1;
            end
            step();
            cyc++;
            if (!fin) check("rnd_wait_valid", bus.result_valid, 1'b0);
        end
        bus.lane_done = '0;
        bus.product   = rand_prod();
        check("rnd_valid",  bus.result_valid, 1'b1);
        check("rnd_result", bus.result, er);
        check("rnd_err",    bus.err, ee);
        for (int i = 0; i < delay; i++) begin
            bus.start = 1'($urandom_range(1));
            step();
            check("rnd_hold_valid",  bus.result_valid, 1'b1);
            check("rnd_hold_result", bus.result, er);
            check("rnd_hold_err",    bus.err, ee);
        end
        bus.start = 1'b0;
        release_op("rnd");
    endtask

    initial begin
        vectors          = 0;
        miscompares      = 0;
        reset            = 1'b1;
        bus.start        = 1'b0;
        bus.sew          = 2'b00;
        bus.hi_sel       = 1'b0;
        bus.lane_done    = '0;
        bus.product      = '0;
        bus.result_ready = 1'b0;
        step();
        step();
        check("rst_valid",  bus.result_valid, 1'b0);
        check("rst_busy",   bus.busy, 1'b0);
        check("rst_err",    bus.err, 2'b00);
        check("rst_result", bus.result, '0);
        reset = 1'b0;
        step();

        // 32-bit low half, all lanes done in one cycle
        prod = {c_LANES{64'h0000_0001_FFFF_FFFE}};
        issue(2'b10, 1'b0);
        check("s32_busy", bus.busy, 1'b1);
        bus.product   = prod;
        bus.lane_done = '1;
        step();
        bus.lane_done = '0;
        check("s32_valid",  bus.result_valid, 1'b1);
        check("s32_result", bus.result, ref_vec(prod, 2'b10, 1'b0));
        word = bus.result[31:0];
        check("s32_word",   word, 32'hFFFF_FFFE);
        check("s32_err",    bus.err, 2'b00);
        release_op("s32");

        // 8-bit high half, one lane per cycle
        prod = {c_LANES{64'h1234_5678_9ABC_DEF0}};
        issue(2'b00, 1'b1);
        bus.product = prod;
        for (int l = 0; l < c_LANES; l++) begin
            bus.lane_done = c_LANES'(1) << l;
            step();
            if (l < c_LANES - 1) check("s8_early_valid", bus.result_valid, 1'b0);
        end
        bus.lane_done = '0;
        check("s8_valid",  bus.result_valid, 1'b1);
        check("s8_result", bus.result, ref_vec(prod, 2'b00, 1'b1));
        word = bus.result[32*15 +: 32];
        check("s8_word",   word, 32'h1256_9ADE);
        check("s8_err",    bus.err, 2'b00);
        release_op("s8");

        // Lane 7 stuck: timeout after TIMEOUT_CYCLES WAIT cycles
        issue(2'b10, 1'b0);
        bus.lane_done = 16'hFF7F;
        bus.product   = rand_prod();
        n = 0;
        while (!bus.result_valid && n < 200) begin
            step();
            n++;
        end
        bus.lane_done = '0;
        check("to_cycles", n, c_TIMEOUT);
        check("to_valid",  bus.result_valid, 1'b1);
        check("to_result", bus.result, '0);
        check("to_err",    bus.err, 2'b01);
        release_op("to");

        // Last lane arrives in the timeout cycle: completion wins
        issue(2'b01, 1'b1);
        bus.lane_done = 16'hFFFE;
        step();
        bus.lane_done = '0;
        for (int i = 0; i < c_TIMEOUT - 2; i++) step();
        check("race_pre_valid", bus.result_valid, 1'b0);
        prod          = rand_prod();
        bus.product   = prod;
        bus.lane_done = 16'h0001;
        step();
        bus.lane_done = '0;
        check("race_valid",  bus.result_valid, 1'b1);
        check("race_err",    bus.err, 2'b00);
        check("race_result", bus.result, ref_vec(prod, 2'b01, 1'b1));
        release_op("race");

        // Backpressure with start pulses in HOLD and on the handshake cycle
        prod = rand_prod();
        issue(2'b01, 1'b0);
        bus.product   = prod;
        bus.lane_done = '1;
        step();
        bus.lane_done = '0;
        bus.product   = rand_prod();
        exp_res = ref_vec(prod, 2'b01, 1'b0);
        check("bp_result", bus.result, exp_res);
        held = bus.result;
        for (int i = 0; i < 10; i++) begin
            bus.start = 1'(i % 2);
            step();
            check("bp_hold_result", bus.result, exp_res);
            check("bp_hold_valid",  bus.result_valid, 1'b1);
        end
        bus.start        = 1'b1;
        bus.result_ready = 1'b1;
        step();
        bus.start        = 1'b0;
        bus.result_ready = 1'b0;
        check("bp_rel_valid", bus.result_valid, 1'b0);
        check("bp_rel_busy",  bus.busy, 1'b0);
        step();
        check("bp_start_ignored", bus.busy, 1'b0);

        // Reset mid-WAIT after 8 lanes, with start held during reset
        issue(2'b10, 1'b0);
        bus.product = rand_prod();
        for (int l = 0; l < 8; l++) begin
            bus.lane_done = c_LANES'(1) << l;
            step();
        end
        bus.lane_done = '0;
        reset     = 1'b1;
        bus.start = 1'b1;
        step();
        reset     = 1'b0;
        bus.start = 1'b0;
        check("mr_valid",  bus.result_valid, 1'b0);
        check("mr_busy",   bus.busy, 1'b0);
        check("mr_result", bus.result, '0);
        check("mr_err",    bus.err, 2'b00);
        step();
        check("mr_start_ignored", bus.busy, 1'b0);
        prod = rand_prod();
        issue(2'b10, 1'b1);
        bus.product   = prod;
        bus.lane_done = 16'hFF00;
        for (int i = 0; i < 5; i++) step();
        check("mr_partial_valid", bus.result_valid, 1'b0);
        bus.lane_done = 16'h00FF;
        step();
        bus.lane_done = '0;
        check("mr_valid2",  bus.result_valid, 1'b1);
        check("mr_result2", bus.result, ref_vec(prod, 2'b10, 1'b1));
        release_op("mr");

        // Reserved element width
        issue(2'b11, 1'b0);
        bus.product   = rand_prod();
        bus.lane_done = '1;
        step();
        bus.lane_done = '0;
        check("rsv_valid",  bus.result_valid, 1'b1);
        check("rsv_result", bus.result, '0);
        check("rsv_err",    bus.err, 2'b10);
        release_op("rsv");

        // Randomized operations
        for (int i = 0; i < 24; i++) begin
            run_random(2'($urandom_range(3)), 1'($urandom_range(1)),
                       15 + int'($urandom_range(60)), int'($urandom_range(4)));
        end
        run_random(2'b00, 1'b0, 0, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_mul_result_collector
`default_nettype wire
